// File: rtl/d_prob.sv
// Clipped-score distance: compares a signed prediction against a saturated
// threshold target and registers half the absolute gap, one cycle of latency.
module d_prob #(
  parameter int T_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [T_WIDTH:0]   T,
  input  logic [T_WIDTH:0]   q,
  input  logic [T_WIDTH:0]   v,
  output logic [T_WIDTH-1:0] d
);

  localparam int AW = T_WIDTH + 3;

  logic [T_WIDTH-1:0] te;
  logic signed [AW-1:0] te_s;
  logic signed [AW-1:0] t_s;
  logic signed [AW-1:0] v_s;
  logic signed [AW-1:0] vc_s;
  logic signed [AW-1:0] diff_s;
  logic [AW-1:0]        mag;
  logic [AW-1:0]        half;
  logic [T_WIDTH-1:0]   d_next;
  logic [T_WIDTH-1:0]   d_reg;

  // T has one extra magnitude bit; any value with it set saturates to all ones.
  assign te = T[T_WIDTH] ? {T_WIDTH{1'b1}} : T[T_WIDTH-1:0];

  always_comb begin
    te_s   = $signed({3'b000, te});
    v_s    = $signed({{2{v[T_WIDTH]}}, v});
    t_s    = (q != '0) ? te_s : -te_s;
    vc_s   = v_s;
    if (v_s > te_s) begin
      vc_s = te_s;
    end else if (v_s < -te_s) begin
      vc_s = -te_s;
    end
    diff_s = t_s - vc_s;
    mag    = (diff_s < 0) ? $unsigned(-diff_s) : $unsigned(diff_s);
    half   = mag >> 1;
    // |t - vc| <= 2*Te, so the halved value always fits in T_WIDTH bits.
    d_next = half[T_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= '0;
    end else begin
      d_reg <= d_next;
    end
  end

  assign d = d_reg;

endmodule

// File: tb/tb_d_prob.sv
// Self-checking bench for d_prob: directed scenarios, reset behaviour and
// randomized inputs checked against an integer reference model.
module tb_d_prob;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W:0]   T;
  logic [W:0]   q;
  logic [W:0]   v;
  logic [W-1:0] d;

  int errors;
  int checks;

  d_prob #(.T_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .T    (T),
    .q    (q),
    .v    (v),
    .d    (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic straight from the clip-and-halve rule.
  function automatic int model(input int t_in, input int q_in, input int v_in);
    int te, tgt, vc, diff;
    te   = (t_in > (1 << W) - 1) ? (1 << W) - 1 : t_in;
    tgt  = (q_in != 0) ? te : -te;
    vc   = (v_in > te) ? te : ((v_in < -te) ? -te : v_in);
    diff = tgt - vc;
    if (diff < 0) diff = -diff;
    return diff / 2;
  endfunction

  task automatic check(input string tag, input int exp);
    logic [W-1:0] e;
    e = W'(exp);
    checks++;
    assert (d === e) else begin
      errors++;
      $error("FAIL %s: d=%0d expected %0d", tag, d, e);
    end
  endtask

  // Drive a new input set on the falling edge, return just after the rising edge.
  task automatic apply(input int t_i, input int q_i, input int v_i);
    @(negedge clk);
    T = (W+1)'(t_i);
    q = (W+1)'(q_i);
    v = (W+1)'(v_i);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input int t_i, input int q_i,
                          input int v_i, input int exp);
    apply(t_i, q_i, v_i);
    $display("txn %s T=%0d q=%0d v=%0d d=%0d", tag, t_i, q_i, v_i, d);
    check(tag, exp);
  endtask

  initial begin
    int t_r, q_r, v_r, exp_r;
    errors = 0;
    checks = 0;
    T = '0;
    q = '0;
    v = '0;
    rst_n = 1'b1;

    #2 rst_n = 1'b0;
    #1 check("reset_async", 0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", 0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("neg_v20",       36, 0,   20, 28);
    directed("pos_v0",        36, 1,    0, 18);
    directed("pos_clip_hi",   36, 1,   50,  0);
    directed("neg_clip_lo",   36, 0,  -60,  0);
    directed("neg_vm20",      36, 0,  -20,  8);
    directed("pos_vm255",     36, 1, -255, 36);
    directed("odd_diff",      36, 1,    1, 17);
    directed("v_most_neg",    36, 1, -256, 36);
    directed("vc_eq_t",       36, 0,  -36,  0);
    directed("t_saturate",   511, 1, -256, 255);
    directed("t_256",        256, 0,  255, 255);
    directed("te0_a",          0, 1,  100,  0);
    directed("te0_b",          0, 0, -256,  0);

    // Reset asserted between edges while a nonzero result is held.
    directed("pre_reset",     36, 0,   20, 28);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_op", 0);
    @(posedge clk);
    #1 check("reset_mid_held", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_after_release", 28);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       t_r = $urandom_range(0, 3);
        1:       t_r = $urandom_range(256, 511);
        default: t_r = $urandom_range(0, 511);
      endcase
      q_r   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 511);
      v_r   = $urandom_range(0, 511) - 256;
      exp_r = model(t_r, q_r, v_r);
      apply(t_r, q_r, v_r);
      $display("txn rnd%0d T=%0d q=%0d v=%0d d=%0d exp=%0d", i, t_r, q_r, v_r, d, exp_r);
      check("random", exp_r);
      // Inputs changing between edges must not disturb the registered result.
      T = (W+1)'($urandom);
      q = (W+1)'($urandom);
      v = (W+1)'($urandom);
      #2 check("hold_between_edges", exp_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
